// File: rtl/fp_round_if.sv
// Stream interface for fp_round_pipe: input beat, rounding-mode CSR and rounded result.
// master = producer/consumer side, slave = the rounding unit.
interface fp_round_if #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
);
    localparam int unsigned W = EXP_W + FRAC_W;

    logic         in_valid;
    logic         in_ready;
    logic         in_sign;
    logic [W-1:0] in_exp_frac;
    logic [2:0]   in_grs;
    logic [2:0]   in_rm;
    logic         in_special;
    logic [2:0]   frm;

    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [W-1:0] out_exp_frac;
    logic         out_nx;
    logic         out_of;
    logic         out_nv;

    modport master (
        output in_valid, in_sign, in_exp_frac, in_grs, in_rm, in_special, frm, out_ready,
        input  in_ready, out_valid, out_sign, out_exp_frac, out_nx, out_of, out_nv
    );

    modport slave (
        input  in_valid, in_sign, in_exp_frac, in_grs, in_rm, in_special, frm, out_ready,
        output in_ready, out_valid, out_sign, out_exp_frac, out_nx, out_of, out_nv
    );
endinterface

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 rounding back end with overflow saturation and valid/ready backpressure.
// Define FP_ROUND_DYN_RM_EN to let in_rm=111 resolve to frm.
module fp_round_pipe #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input logic       clk,
    input logic       rst_n,
    fp_round_if.slave io
);
    localparam int unsigned W = EXP_W + FRAC_W;
    localparam logic [W-1:0] InfVal    = {{EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    localparam logic [W-1:0] MaxFinite = {{(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};

    typedef enum logic [2:0] {
        RmRne = 3'b000,
        RmRz  = 3'b001,
        RmRdn = 3'b010,
        RmRup = 3'b011,
        RmRmm = 3'b100
    } rm_e;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_v_q, s1_v_d;
    logic s2_v_q, s2_v_d;
    logic s1_acc, s2_acc;
    logic s1_load, s2_load;

    always_comb begin
        s2_acc  = ~s2_v_q | io.out_ready;
        s1_acc  = ~s1_v_q | s2_acc;
        s1_load = io.in_valid & s1_acc;
        s2_load = s1_v_q & s2_acc;
        s1_v_d  = s1_acc ? io.in_valid : s1_v_q;
        s2_v_d  = s2_acc ? s1_v_q : s2_v_q;
    end

    assign io.in_ready = s1_acc;

    // ------------------------------------------------------------------
    // Stage 1: resolve rounding mode, decide increment
    // ------------------------------------------------------------------
    logic [2:0] rm_req;
    rm_e        rm_res;
    logic       nv_new;
    logic       g_bit, r_bit, s_bit, lsb_bit;
    logic       inc_raw;
    logic       any_rem;

    always_comb begin
        rm_req = io.in_rm;
`ifdef FP_ROUND_DYN_RM_EN
        if (io.in_rm == 3'b111) begin
            rm_req = io.frm;
        end
`endif
        nv_new = 1'b0;
        case (rm_req)
            3'b000:  rm_res = RmRne;
            3'b001:  rm_res = RmRz;
            3'b010:  rm_res = RmRdn;
            3'b011:  rm_res = RmRup;
            3'b100:  rm_res = RmRmm;
            default: begin
                rm_res = RmRne;
                nv_new = 1'b1;
            end
        endcase
    end

`ifndef FP_ROUND_DYN_RM_EN
    logic unused_frm;
    assign unused_frm = ^io.frm;
`endif

    always_comb begin
        {g_bit, r_bit, s_bit} = io.in_grs;
        lsb_bit = io.in_exp_frac[0];
        any_rem = g_bit | r_bit | s_bit;
        case (rm_res)
            RmRne:   inc_raw = g_bit & (lsb_bit | r_bit | s_bit);
            RmRz:    inc_raw = 1'b0;
            RmRdn:   inc_raw = io.in_sign & any_rem;
            RmRup:   inc_raw = ~io.in_sign & any_rem;
            RmRmm:   inc_raw = g_bit;
            default: inc_raw = 1'b0;
        endcase
    end

    logic         s1_sign_q, s1_sign_d;
    logic [W-1:0] s1_ef_q, s1_ef_d;
    logic         s1_inc_q, s1_inc_d;
    logic         s1_nx_q, s1_nx_d;
    rm_e          s1_rm_q, s1_rm_d;
    logic         s1_special_q, s1_special_d;
    logic         s1_nv_q, s1_nv_d;

    always_comb begin
        s1_sign_d    = s1_sign_q;
        s1_ef_d      = s1_ef_q;
        s1_inc_d     = s1_inc_q;
        s1_nx_d      = s1_nx_q;
        s1_rm_d      = s1_rm_q;
        s1_special_d = s1_special_q;
        s1_nv_d      = s1_nv_q;
        if (s1_load) begin
            s1_sign_d    = io.in_sign;
            s1_ef_d      = io.in_exp_frac;
            // Special operands pass through untouched and never raise nx.
            s1_inc_d     = inc_raw & ~io.in_special;
            s1_nx_d      = any_rem & ~io.in_special;
            s1_rm_d      = rm_res;
            s1_special_d = io.in_special;
            s1_nv_d      = nv_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q       <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_ef_q      <= '0;
            s1_inc_q     <= 1'b0;
            s1_nx_q      <= 1'b0;
            s1_rm_q      <= RmRne;
            s1_special_q <= 1'b0;
            s1_nv_q      <= 1'b0;
        end else begin
            s1_v_q       <= s1_v_d;
            s1_sign_q    <= s1_sign_d;
            s1_ef_q      <= s1_ef_d;
            s1_inc_q     <= s1_inc_d;
            s1_nx_q      <= s1_nx_d;
            s1_rm_q      <= s1_rm_d;
            s1_special_q <= s1_special_d;
            s1_nv_q      <= s1_nv_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: increment, overflow saturation
    // ------------------------------------------------------------------
    logic [W-1:0] sum;
    logic         ovf;
    logic         to_inf;
    logic [W-1:0] res_ef;
    logic         res_nx;
    logic         res_of;

    always_comb begin
        // Carry out of the fraction deliberately ripples into the exponent.
        sum = s1_ef_q + {{(W-1){1'b0}}, s1_inc_q};
        ovf = (&sum[W-1 -: EXP_W]) & ~s1_special_q;
        case (s1_rm_q)
            RmRne:   to_inf = 1'b1;
            RmRmm:   to_inf = 1'b1;
            RmRdn:   to_inf = s1_sign_q;
            RmRup:   to_inf = ~s1_sign_q;
            default: to_inf = 1'b0;
        endcase
        res_ef = sum;
        res_nx = s1_nx_q;
        res_of = 1'b0;
        if (ovf) begin
            res_ef = to_inf ? InfVal : MaxFinite;
            res_nx = 1'b1;
            res_of = 1'b1;
        end
    end

    logic         out_sign_q, out_sign_d;
    logic [W-1:0] out_ef_q, out_ef_d;
    logic         out_nx_q, out_nx_d;
    logic         out_of_q, out_of_d;
    logic         out_nv_q, out_nv_d;

    always_comb begin
        out_sign_d = out_sign_q;
        out_ef_d   = out_ef_q;
        out_nx_d   = out_nx_q;
        out_of_d   = out_of_q;
        out_nv_d   = out_nv_q;
        if (s2_load) begin
            out_sign_d = s1_sign_q;
            out_ef_d   = res_ef;
            out_nx_d   = res_nx;
            out_of_d   = res_of;
            out_nv_d   = s1_nv_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q     <= 1'b0;
            out_sign_q <= 1'b0;
            out_ef_q   <= '0;
            out_nx_q   <= 1'b0;
            out_of_q   <= 1'b0;
            out_nv_q   <= 1'b0;
        end else begin
            s2_v_q     <= s2_v_d;
            out_sign_q <= out_sign_d;
            out_ef_q   <= out_ef_d;
            out_nx_q   <= out_nx_d;
            out_of_q   <= out_of_d;
            out_nv_q   <= out_nv_d;
        end
    end

    assign io.out_valid    = s2_v_q;
    assign io.out_sign     = out_sign_q;
    assign io.out_exp_frac = out_ef_q;
    assign io.out_nx       = out_nx_q;
    assign io.out_of       = out_of_q;
    assign io.out_nv       = out_nv_q;

`ifndef SYNTHESIS
    a_stall_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (io.out_valid && !io.out_ready) |=>
            (io.out_valid && $stable(io.out_exp_frac) && $stable(io.out_sign)));
    a_ready_path : assert property (@(posedge clk) disable iff (!rst_n)
        io.out_ready |-> io.in_ready);
`endif

endmodule
